// File: rtl/mac_dot_sequencer_if.sv
// Operand stream from the host buffer plus the full MAC input/output bus,
// grouped so the sequencer is the single driver of every MAC input.
interface mac_dot_sequencer_if;
  // Operand stream: a pair moves on every rising edge where op_valid and
  // op_ready are both high. The source holds op_a/op_b steady while
  // op_valid is high and op_ready is low. op_ready never waits on op_valid.
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;

  logic [2:0]  mac_instruction;
  logic [15:0] mac_multiplier;
  logic [15:0] mac_multiplicand;
  logic        mac_stall;
  logic [31:0] mac_result;
  logic [7:0]  mac_protect;

  modport master (
    output op_valid, op_a, op_b, mac_result, mac_protect,
    input  op_ready, mac_instruction, mac_multiplier, mac_multiplicand, mac_stall
  );

  modport slave (
    input  op_valid, op_a, op_b, mac_result, mac_protect,
    output op_ready, mac_instruction, mac_multiplier, mac_multiplicand, mac_stall
  );
endinterface

// File: rtl/mac_dot_sequencer.sv
// Dot-product job controller: clears the MAC, streams N operand pairs into it,
// lets the saturate stage settle, then captures the final result.
module mac_dot_sequencer #(
  parameter int LEN_W        = 8,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mode,
  input  logic [LEN_W-1:0] length,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      job_result,
  output logic [7:0]       job_protect,
  output logic [2:0]       dbg_state,
  mac_dot_sequencer_if.slave bus
);

  localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [LEN_W-1:0]   LEN_ONE    = LEN_W'(1);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);

  logic [2:0]         state_q;
  logic               mode_q;
  logic               first_q;
  logic [LEN_W-1:0]   remain_q;
  logic [DRAIN_W-1:0] drain_q;
  logic               xfer;

  assign xfer      = (state_q == S_ISSUE) && bus.op_valid;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      first_q     <= 1'b0;
      remain_q    <= '0;
      drain_q     <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      job_result  <= '0;
      job_protect <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // The done cycle is already IDLE; a start there is deliberately dropped.
          if (start && !done) begin
            if (length == '0) begin
              err <= 1'b1;
            end else begin
              mode_q   <= mode;
              remain_q <= length;
              state_q  <= S_CLEAR;
            end
          end
        end
        S_CLEAR: begin
          first_q <= 1'b1;
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          if (xfer) begin
            first_q  <= 1'b0;
            remain_q <= remain_q - LEN_ONE;
            if (remain_q == LEN_ONE) begin
              drain_q <= DRAIN_LOAD;
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          drain_q <= drain_q - DRAIN_ONE;
          if (drain_q == DRAIN_ONE) state_q <= S_DONE;
        end
        S_DONE: begin
          job_result  <= bus.mac_result;
          job_protect <= bus.mac_protect;
          done        <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Instruction low bits: 0 clear, 1 load product, 2 accumulate, 3 saturate/hold;
  // bit 2 selects the dual 8-bit lane variant.
  always_comb begin
    bus.op_ready         = 1'b0;
    bus.mac_stall        = 1'b1;
    bus.mac_instruction  = 3'd0;
    bus.mac_multiplier   = '0;
    bus.mac_multiplicand = '0;
    case (state_q)
      S_CLEAR: begin
        bus.mac_stall       = 1'b0;
        bus.mac_instruction = {mode_q, 2'b00};
      end
      S_ISSUE: begin
        bus.op_ready         = 1'b1;
        bus.mac_stall        = !bus.op_valid;
        bus.mac_instruction  = {mode_q, first_q ? 2'b01 : 2'b10};
        bus.mac_multiplier   = bus.op_a;
        bus.mac_multiplicand = bus.op_b;
      end
      S_DRAIN: begin
        bus.mac_stall       = 1'b0;
        bus.mac_instruction = {mode_q, 2'b11};
      end
      S_DONE: begin
        bus.mac_instruction = {mode_q, 2'b11};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer: behavioural MAC on the bus, closed-form dot
// product reference, directed plan scenarios followed by random jobs.
module tb_mac_dot_sequencer;
  localparam int LEN_W = 8;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             mode = 1'b0;
  logic [LEN_W-1:0] length = '0;
  logic             busy, done, err;
  logic [31:0]      job_result;
  logic [7:0]       job_protect;
  logic [2:0]       dbg_state;

  mac_dot_sequencer_if bus();

  mac_dot_sequencer #(.LEN_W(LEN_W), .DRAIN_CYCLES(3)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .mode        (mode),
    .length      (length),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .job_result  (job_result),
    .job_protect (job_protect),
    .dbg_state   (dbg_state),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // ---------------- behavioural MAC ----------------
  logic signed [39:0] acc = '0;
  logic signed [19:0] acc_hi = '0;
  logic signed [19:0] acc_lo = '0;
  logic [31:0]        mres = '0;
  logic [7:0]         mprot = '0;
  logic signed [39:0] p16;
  logic signed [19:0] p_hi, p_lo;

  assign p16  = 40'($signed(bus.mac_multiplier)) * 40'($signed(bus.mac_multiplicand));
  assign p_hi = 20'($signed(bus.mac_multiplier[15:8])) * 20'($signed(bus.mac_multiplicand[15:8]));
  assign p_lo = 20'($signed(bus.mac_multiplier[7:0])) * 20'($signed(bus.mac_multiplicand[7:0]));
  assign bus.mac_result  = mres;
  assign bus.mac_protect = mprot;

  function automatic logic [31:0] sat32(input logic signed [39:0] v);
    if (v > 40'sh007FFFFFFF) return 32'h7FFFFFFF;
    if (v < -40'sh0080000000) return 32'h80000000;
    return v[31:0];
  endfunction

  function automatic logic [15:0] sat16(input logic signed [19:0] v);
    if (v > 20'sh07FFF) return 16'h7FFF;
    if (v < -20'sh08000) return 16'h8000;
    return v[15:0];
  endfunction

  always @(posedge clk) begin
    if (!bus.mac_stall) begin
      case (bus.mac_instruction)
        3'd0: acc <= '0;
        3'd1: acc <= p16;
        3'd2: acc <= acc + p16;
        3'd3: begin mres <= sat32(acc); mprot <= acc[39:32]; end
        3'd4: begin acc_hi <= '0; acc_lo <= '0; end
        3'd5: begin acc_hi <= p_hi; acc_lo <= p_lo; end
        3'd6: begin acc_hi <= acc_hi + p_hi; acc_lo <= acc_lo + p_lo; end
        default: begin
          mres  <= {sat16(acc_hi), sat16(acc_lo)};
          mprot <= {acc_hi[19:16], acc_lo[19:16]};
        end
      endcase
    end
  end

  // ---------------- monitor ----------------
  logic [2:0] seen_q[$];
  logic [2:0] exp_q[$];
  bit         mon_en = 1'b0;
  int         stall_cnt = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!bus.mac_stall) seen_q.push_back(bus.mac_instruction);
      else if (busy) stall_cnt++;
    end
  end

  // ---------------- stimulus storage / reference ----------------
  logic [15:0] pa[$];
  logic [15:0] pb[$];
  int          gap[$];

  task automatic clear_pairs();
    pa.delete(); pb.delete(); gap.delete();
  endtask

  task automatic add_pair(input logic [15:0] a, input logic [15:0] b, input int g);
    pa.push_back(a); pb.push_back(b); gap.push_back(g);
  endtask

  function automatic void ref_model(input logic m, input int n,
                                    output logic [31:0] r, output logic [7:0] p);
    longint s;
    int hi, lo, hs, ls;
    s = 0; hi = 0; lo = 0;
    for (int i = 0; i < n; i++) begin
      s  += longint'($signed(pa[i])) * longint'($signed(pb[i]));
      hi += int'($signed(pa[i][15:8])) * int'($signed(pb[i][15:8]));
      lo += int'($signed(pa[i][7:0])) * int'($signed(pb[i][7:0]));
    end
    if (!m) begin
      if (s > 64'sd2147483647) r = 32'h7FFFFFFF;
      else if (s < -64'sd2147483648) r = 32'h80000000;
      else r = s[31:0];
      p = s[39:32];
    end else begin
      hs = (hi > 32767) ? 32767 : ((hi < -32768) ? -32768 : hi);
      ls = (lo > 32767) ? 32767 : ((lo < -32768) ? -32768 : lo);
      r = {hs[15:0], ls[15:0]};
      p = {hi[19:16], lo[19:16]};
    end
  endfunction

  // ---------------- checking / driver ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_job(input logic m, input int n, input bit poke, input string tag);
    logic [31:0] er;
    logic [7:0]  ep;
    int base_seen, base_stall, t0, gaps, wait_n;
    ref_model(m, n, er, ep);
    gaps = 0;
    for (int i = 1; i < n; i++) gaps += gap[i];

    @(negedge clk);
    start = 1'b1; mode = m; length = LEN_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
    base_seen  = seen_q.size();
    base_stall = stall_cnt;
    mon_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap[i]; g++) begin
        bus.op_valid = 1'b0;
        @(negedge clk);
      end
      bus.op_valid = 1'b1; bus.op_a = pa[i]; bus.op_b = pb[i];
      if (poke && i == 1) begin start = 1'b1; length = LEN_W'(5); end
      wait_n = 0;
      while (!bus.op_ready && wait_n < 20) begin @(negedge clk); wait_n++; end
      check({tag, ".ready"}, bus.op_ready, 1'b1);
      @(negedge clk);
      start = 1'b0;
    end
    bus.op_valid = 1'b0;
    bus.op_a = 16'($urandom); bus.op_b = 16'($urandom);

    wait_n = 0;
    while (!done && wait_n < 40) begin @(negedge clk); wait_n++; end
    check({tag, ".done"}, done, 1'b1);
    check({tag, ".latency"}, cyc - t0, n + 5 + gaps);
    check({tag, ".result"}, job_result, er);
    check({tag, ".protect"}, job_protect, ep);
    check({tag, ".busy_at_done"}, busy, 1'b0);

    // start coinciding with done must be dropped
    start = 1'b1; length = LEN_W'(3);
    @(negedge clk);
    start = 1'b0;
    check({tag, ".start_in_done_ignored"}, busy, 1'b0);
    check({tag, ".no_err"}, err, 1'b0);
    mon_en = 1'b0;

    exp_q.delete();
    exp_q.push_back({m, 2'b00});
    exp_q.push_back({m, 2'b01});
    for (int i = 1; i < n; i++) exp_q.push_back({m, 2'b10});
    for (int i = 0; i < 3; i++) exp_q.push_back({m, 2'b11});
    check({tag, ".instr_count"}, seen_q.size() - base_seen, exp_q.size());
    for (int k = 0; k < exp_q.size() && base_seen + k < seen_q.size(); k++)
      check($sformatf("%s.instr%0d", tag, k), seen_q[base_seen + k], exp_q[k]);
    check({tag, ".stall_cycles"}, stall_cnt - base_stall, gaps + 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bus.op_valid = 1'b0; bus.op_a = '0; bus.op_b = '0;
    repeat (3) @(negedge clk);
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.err", err, 1'b0);
    check("rst.op_ready", bus.op_ready, 1'b0);
    check("rst.job_result", job_result, 32'h0);
    check("rst.job_protect", job_protect, 8'h0);
    check("rst.instr", bus.mac_instruction, 3'd0);
    check("rst.stall", bus.mac_stall, 1'b1);
    reset_n = 1'b1;
    @(negedge clk);

    clear_pairs();
    add_pair(16'd2, 16'd3, 0); add_pair(16'd4, 16'd5, 0); add_pair(16'hFFFA, 16'd7, 0);
    run_job(1'b0, 3, 1'b0, "dot16");
    check("dot16.const_result", job_result, 32'hFFFFFFF0);
    check("dot16.const_protect", job_protect, 8'hFF);

    clear_pairs();
    add_pair(16'h0302, 16'h0504, 0); add_pair(16'h0302, 16'h0504, 0);
    run_job(1'b1, 2, 1'b0, "dot8");
    check("dot8.const_result", job_result, 32'h001E0010);
    check("dot8.const_protect", job_protect, 8'h00);

    clear_pairs();
    for (int i = 0; i < 4; i++) add_pair(16'h8000, 16'h8000, 0);
    run_job(1'b0, 4, 1'b0, "sat16");
    check("sat16.const_result", job_result, 32'h7FFFFFFF);
    check("sat16.const_protect", job_protect, 8'h01);

    clear_pairs();
    add_pair(16'd2, 16'd3, 0); add_pair(16'd4, 16'd5, 5); add_pair(16'hFFFA, 16'd7, 0);
    run_job(1'b0, 3, 1'b0, "stall5");
    check("stall5.const_result", job_result, 32'hFFFFFFF0);

    @(negedge clk);
    start = 1'b1; length = '0;
    @(negedge clk);
    start = 1'b0;
    check("len0.err", err, 1'b1);
    check("len0.busy", busy, 1'b0);
    @(negedge clk);
    check("len0.err_pulse", err, 1'b0);

    clear_pairs();
    add_pair(16'd2, 16'd3, 0); add_pair(16'd4, 16'd5, 0); add_pair(16'hFFFA, 16'd7, 0);
    run_job(1'b0, 3, 1'b1, "poke");

    // reset pulse in the middle of ISSUE
    @(negedge clk);
    start = 1'b1; mode = 1'b0; length = LEN_W'(4);
    @(negedge clk);
    start = 1'b0;
    bus.op_valid = 1'b1; bus.op_a = 16'd9; bus.op_b = 16'd9;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0; bus.op_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("midrst.busy", busy, 1'b0);
    check("midrst.stall", bus.mac_stall, 1'b1);
    check("midrst.job_result", job_result, 32'h0);
    check("midrst.job_protect", job_protect, 8'h0);
    check("midrst.state", dbg_state, 3'd0);
    check("midrst.op_ready", bus.op_ready, 1'b0);

    clear_pairs();
    add_pair(16'h1234, 16'hFF00, 0); add_pair(16'h7FFF, 16'h0002, 1);
    run_job(1'b0, 2, 1'b0, "after_rst");

    for (int j = 0; j < 8; j++) begin
      logic m;
      int   n;
      m = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 12);
      clear_pairs();
      for (int i = 0; i < n; i++)
        add_pair(16'($urandom), 16'($urandom), (i == 0) ? 0 : $urandom_range(0, 2));
      run_job(m, n, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", j));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
